demux_1to4_stream: RTL and testbench

Stream demultiplexer: routes N-bit words from one valid/ready input to one of four output lanes A/B/C/D selected by S[1:0], the inverse of the team's 4-to-1 mux datapath. Each lane has a one-entry registered buffer, so outputs are registered and lanes back-pressure independently. Packets marked by `in_last` are kept whole on one lane: the select is locked from the first beat through the last beat. Sits between a single producer (e.g. an input FIFO) and four consumer pipelines.

---
 rtl/demux_pkg.sv | 28 ++
 rtl/lane_buffer.sv | 37 +++
 rtl/demux_1to4_stream.sv | 132 +++++++++++++
 tb/tb_demux_1to4_stream.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 stream demultiplexer: lane indices,
// packet-lock FSM encoding and the optional per-lane packet-counter helpers.
package demux_pkg;

   localparam logic [1:0] LANE_A = 2'd0;
   localparam logic [1:0] LANE_B = 2'd1;
   localparam logic [1:0] LANE_C = 2'd2;
   localparam logic [1:0] LANE_D = 2'd3;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int STAT_W = 16;
   localparam logic [STAT_W-1:0] STAT_ONE = 16'h0001;
   localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

   // Saturating increment for the packet counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
      if (value == STAT_MAX) begin
         return value;
      end else begin
         return value + STAT_ONE;
      end
   endfunction

endpackage

// File: rtl/lane_buffer.sv
// One-entry registered output slice for a single demux lane. A write always
// loads the slot (also when the consumer drains it in the same cycle); data
// and last hold their values after a drain.
module lane_buffer
   import demux_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [N-1:0] wr_data,
   input  logic         wr_last,
   input  logic         rd_ready,
   output logic [N-1:0] data,
   output logic         last,
   output logic         valid
);

   // Slot register: load on write, clear valid on a drain without refill.
   always_ff @(posedge clk) begin
      if (rst) begin
         data  <= {N{1'b0}};
         last  <= 1'b0;
         valid <= 1'b0;
      end else if (wr_en) begin
         data  <= wr_data;
         last  <= wr_last;
         valid <= 1'b1;
      end else if (valid && rd_ready) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

endmodule

// File: rtl/demux_1to4_stream.sv
// Valid/ready stream demultiplexer: one input routed to four registered lanes.
// The lane select is sampled on a packet's first beat and locked until in_last.
// Optional feature macro: DEMUX_STATS_EN adds saturating per-lane packet counters
// on output pkt_count.
module demux_1to4_stream
   import demux_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] in_data,
   input  logic [1:0]   S,
   input  logic         in_last,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] A,
   output logic [N-1:0] B,
   output logic [N-1:0] C,
   output logic [N-1:0] D,
   output logic [3:0]   out_last,
   output logic [3:0]   out_valid,
   input  logic [3:0]   out_ready
`ifdef DEMUX_STATS_EN
   ,
   output logic [4*STAT_W-1:0] pkt_count
`endif
);

   state_t       state;
   state_t       state_next;
   logic [1:0]   locked_sel;
   logic [1:0]   locked_sel_next;
   logic [1:0]   target;
   logic         in_xfer;
   logic [N-1:0] lane_data [4];

   // Target lane: live select between packets, locked select inside a packet.
   always_comb begin
      target = S;
      if (state == LOCKED) begin
         target = locked_sel;
      end else begin
         target = S;
      end
   end

   // Ready depends only on the target lane, so a stalled lane never blocks others.
   assign in_ready = ~out_valid[target] | out_ready[target];
   assign in_xfer  = in_valid & in_ready;

   // Packet-lock FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         locked_sel <= LANE_A;
      end else begin
         state      <= state_next;
         locked_sel <= locked_sel_next;
      end
   end

   // Next-state logic: lock on a non-final first beat, release on the final beat.
   always_comb begin
      state_next      = state;
      locked_sel_next = locked_sel;
      case (state)
         IDLE: begin
            if (in_xfer && !in_last) begin
               state_next      = LOCKED;
               locked_sel_next = S;
            end else begin
               state_next = IDLE;
            end
         end
         LOCKED: begin
            if (in_xfer && in_last) begin
               state_next = IDLE;
            end else begin
               state_next = LOCKED;
            end
         end
         default: begin
            state_next      = IDLE;
            locked_sel_next = LANE_A;
         end
      endcase
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      lane_buffer #(.N(N)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (in_xfer && (target == 2'(g))),
         .wr_data  (in_data),
         .wr_last  (in_last),
         .rd_ready (out_ready[g]),
         .data     (lane_data[g]),
         .last     (out_last[g]),
         .valid    (out_valid[g])
      );
   end

   assign A = lane_data[LANE_A];
   assign B = lane_data[LANE_B];
   assign C = lane_data[LANE_C];
   assign D = lane_data[LANE_D];

`ifdef DEMUX_STATS_EN
   logic [STAT_W-1:0] pkt_cnt [4];

   // Per-lane packet counters: count final beats accepted for each lane.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            pkt_cnt[i] <= {STAT_W{1'b0}};
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (in_xfer && in_last && (target == 2'(i))) begin
               pkt_cnt[i] <= sat_inc(pkt_cnt[i]);
            end else begin
               pkt_cnt[i] <= pkt_cnt[i];
            end
         end
      end
   end

   assign pkt_count = {pkt_cnt[3], pkt_cnt[2], pkt_cnt[1], pkt_cnt[0]};
`endif

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Self-checking bench for demux_1to4_stream: directed scenarios plus random
// traffic, all compared against a lane-slot / packet-lane reference model.
module tb_demux_1to4_stream;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic [1:0] S;
   logic       in_last;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A, B, C, D;
   logic [3:0] out_last;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
`ifdef DEMUX_STATS_EN
   logic [63:0] pkt_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: each lane is a one-word slot; m_lock is the lane of the
   // packet in progress, -1 between packets.
   logic [3:0] m_valid;
   logic [3:0] m_last;
   logic [7:0] m_data [4];
   int         m_lock;
   int         m_cnt [4];
   logic       obs_ready;
   logic       exp_ready;

   always #5 clk = ~clk;

   demux_1to4_stream #(.N(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .S         (S),
      .in_last   (in_last),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .C         (C),
      .D         (D),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
      ,
      .pkt_count (pkt_count)
`endif
   );

   function automatic logic [31:0] m_lanes();
      return {m_data[3], m_data[2], m_data[1], m_data[0]};
   endfunction

   // One clock cycle: drive inputs, sample in_ready mid-cycle, advance the model.
   task automatic tick(input logic r, input logic v, input logic [1:0] s,
                       input logic [7:0] d, input logic l, input logic [3:0] o);
      int t;
      bit xfer;
      rst = r; in_valid = v; S = s; in_data = d; in_last = l; out_ready = o;
      @(negedge clk);
      obs_ready = in_ready;
      t = (m_lock >= 0) ? m_lock : int'(s);
      exp_ready = !m_valid[t] || o[t];
      xfer = v && exp_ready;
      @(posedge clk);
      if (r) begin
         m_valid = 4'b0000; m_last = 4'b0000; m_lock = -1;
         for (int i = 0; i < 4; i++) begin m_data[i] = 8'h00; m_cnt[i] = 0; end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (xfer && i == t) begin
               m_valid[i] = 1'b1; m_data[i] = d; m_last[i] = l;
            end else if (m_valid[i] && o[i]) begin
               m_valid[i] = 1'b0;
            end
         end
         if (xfer) begin
            if (l) begin
               m_lock = -1;
               if (m_cnt[t] < 65535) m_cnt[t]++;
            end else begin
               m_lock = t;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
      tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
      n_checks++;
      if (out_valid !== 4'b0000 || out_last !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: valid=%b last=%b, required 0000/0000", out_valid, out_last);
      end
      n_checks++;
      if ({D, C, B, A} !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h required 00000000", {D, C, B, A});
      end
      tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'h0);
      n_checks++;
      if (obs_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b required 1", obs_ready);
      end
   endtask

   task automatic test_single_beat();
      tick(1'b0, 1'b1, 2'b10, 8'h5A, 1'b1, 4'hF);
      n_checks++;
      if (C !== 8'h5A || out_valid !== 4'b0100 || out_last[2] !== 1'b1) begin
         n_fail++; $display("FAIL single_c: C=%h valid=%b last=%b, required 5a/0100/x1xx", C, out_valid, out_last);
      end
      // still idle: the next single-beat packet follows S to lane A
      tick(1'b0, 1'b1, 2'b00, 8'hA7, 1'b1, 4'hF);
      n_checks++;
      if (A !== 8'hA7 || out_valid !== 4'b0001) begin
         n_fail++; $display("FAIL single_idle: A=%h valid=%b, required a7/0001", A, out_valid);
      end
      n_checks++;
      if ({out_last, out_valid} !== {m_last, m_valid} || {D, C, B, A} !== m_lanes()) begin
         n_fail++; $display("FAIL single_model: got %b/%b %h, required %b/%b %h",
                            out_last, out_valid, {D, C, B, A}, m_last, m_valid, m_lanes());
      end
   endtask

   task automatic test_lock();
      logic [7:0] words [3];
      logic [1:0] sels [3];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      sels[0] = 2'b01; sels[1] = 2'b11; sels[2] = 2'b11;
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b1, sels[k], words[k], (k == 2) ? 1'b1 : 1'b0, 4'hF);
         n_checks++;
         if (B !== words[k] || out_valid !== 4'b0010 || obs_ready !== 1'b1) begin
            n_fail++; $display("FAIL lock_beat%0d: B=%h valid=%b rdy=%b, required %h/0010/1",
                               k, B, out_valid, obs_ready, words[k]);
         end
      end
      n_checks++;
      if (out_last[1] !== 1'b1) begin
         n_fail++; $display("FAIL lock_last: got %b required 1", out_last[1]);
      end
      tick(1'b0, 1'b1, 2'b11, 8'h44, 1'b1, 4'hF);
      n_checks++;
      if (D !== 8'h44 || out_valid !== 4'b1000) begin
         n_fail++; $display("FAIL lock_release: D=%h valid=%b, required 44/1000", D, out_valid);
      end
   endtask

   task automatic test_back_pressure();
      tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
      tick(1'b0, 1'b1, 2'b00, 8'hAA, 1'b1, 4'b1110);
      tick(1'b0, 1'b1, 2'b00, 8'hBB, 1'b1, 4'b1110);
      n_checks++;
      if (obs_ready !== 1'b0 || A !== 8'hAA || out_valid[0] !== 1'b1) begin
         n_fail++; $display("FAIL bp_stall: rdy=%b A=%h v=%b, required 0/aa/1", obs_ready, A, out_valid[0]);
      end
      tick(1'b0, 1'b1, 2'b00, 8'hBB, 1'b1, 4'b1111);
      n_checks++;
      if (obs_ready !== 1'b1 || A !== 8'hBB || out_valid[0] !== 1'b1) begin
         n_fail++; $display("FAIL bp_refill: rdy=%b A=%h v=%b, required 1/bb/1", obs_ready, A, out_valid[0]);
      end
      tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'b1111);
      n_checks++;
      if (out_valid !== 4'b0000 || A !== 8'hBB) begin
         n_fail++; $display("FAIL bp_drain: valid=%b A=%h, required 0000/bb", out_valid, A);
      end
   endtask

   task automatic test_independence();
      tick(1'b0, 1'b1, 2'b00, 8'hC3, 1'b1, 4'b1110);
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, 1'b1, 2'b11, 8'(8'hD0 + k), 1'b1, 4'b1110);
         n_checks++;
         if (obs_ready !== 1'b1 || D !== 8'(8'hD0 + k) || out_valid !== 4'b1001 || A !== 8'hC3) begin
            n_fail++; $display("FAIL indep_%0d: rdy=%b D=%h valid=%b A=%h, required 1/%h/1001/c3",
                               k, obs_ready, D, out_valid, A, 8'(8'hD0 + k));
         end
      end
      tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
   endtask

   task automatic test_mid_reset();
      tick(1'b0, 1'b1, 2'b10, 8'h01, 1'b0, 4'hF);
      tick(1'b0, 1'b1, 2'b10, 8'h02, 1'b0, 4'hF);
      tick(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 4'hF);
      n_checks++;
      if (out_valid !== 4'b0000 || C !== 8'h00) begin
         n_fail++; $display("FAIL mid_reset: valid=%b C=%h, required 0000/00", out_valid, C);
      end
      tick(1'b0, 1'b1, 2'b00, 8'h03, 1'b0, 4'hF);
      n_checks++;
      if (out_valid !== 4'b0001 || A !== 8'h03) begin
         n_fail++; $display("FAIL mid_reset_next: valid=%b A=%h, required 0001/03", out_valid, A);
      end
      tick(1'b0, 1'b1, 2'b10, 8'h04, 1'b1, 4'hF);
      tick(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
   endtask

   task automatic test_random();
      logic       v, l;
      logic [1:0] s;
      logic [7:0] d;
      logic [3:0] o;
      bit         hold = 1'b0;
      int         errs = 0;
      s = 2'b00; d = 8'h00; l = 1'b0; v = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (!hold) begin
            v = ($urandom_range(0, 3) != 0);
            s = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            l = ($urandom_range(0, 2) == 0);
         end
         o = 4'($urandom);
         tick(1'b0, v, s, d, l, o);
         hold = v && !exp_ready;
         n_checks++;
         if (obs_ready !== exp_ready || {out_last, out_valid} !== {m_last, m_valid} ||
             {D, C, B, A} !== m_lanes()) begin
            n_fail++; errs++;
            if (errs < 10)
               $display("FAIL random_%0d: rdy=%b lv=%b/%b lanes=%h, required %b %b/%b %h",
                        k, obs_ready, out_last, out_valid, {D, C, B, A},
                        exp_ready, m_last, m_valid, m_lanes());
         end
      end
   endtask

`ifdef DEMUX_STATS_EN
   task automatic test_stats();
      tick(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 4'hF);
      for (int p = 0; p < 3; p++) begin
         tick(1'b0, 1'b1, 2'b01, 8'h10, 1'b0, 4'hF);
         tick(1'b0, 1'b1, 2'b00, 8'h20, 1'b1, 4'hF);
      end
      for (int p = 0; p < 70000; p++) begin
         tick(1'b0, 1'b1, 2'b00, 8'(p), 1'b1, 4'hF);
      end
      n_checks++;
      if (pkt_count[31:16] !== 16'd3 || m_cnt[1] != 3) begin
         n_fail++; $display("FAIL stats_b: got %0d required 3", pkt_count[31:16]);
      end
      n_checks++;
      if (pkt_count[15:0] !== 16'hFFFF || pkt_count[63:32] !== 32'h0) begin
         n_fail++; $display("FAIL stats_a: got %h required 0000_0000_0003_ffff", pkt_count);
      end
   endtask
`endif

   initial begin
      m_valid = 4'b0000; m_last = 4'b0000; m_lock = -1;
      for (int i = 0; i < 4; i++) begin m_data[i] = 8'h00; m_cnt[i] = 0; end
      test_reset();
      test_single_beat();
      test_lock();
      test_back_pressure();
      test_independence();
      test_mid_reset();
      test_random();
`ifdef DEMUX_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
